// File: rtl/multiword_add_pkg.sv
// Shared types and helpers for the multi-word add sequencer.
package multiword_add_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Slice counter width: enough to hold K-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned k);
    return (k <= 2) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/n_bit_adder_slice.sv
// Combinational N-bit ripple adder; each bit is a full adder made of two half adders.
module n_bit_adder_slice #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    logic ha0_sum, ha0_carry, ha1_carry;
    // First half adder combines the operand bits.
    assign ha0_sum   = a[i] ^ b[i];
    assign ha0_carry = a[i] & b[i];
    // Second half adder folds in the ripple carry.
    assign sum[i]    = ha0_sum ^ carry[i];
    assign ha1_carry = ha0_sum & carry[i];
    assign carry[i+1] = ha0_carry | ha1_carry;
  end

  assign cout = carry[N];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide adder controller: runs one shared N-bit slice over K cycles, LS slice first.
module multiword_add_sequencer
  import multiword_add_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [N*K-1:0] operand_a,
  input  logic [N*K-1:0] operand_b,
  input  logic           carry_in,
  output logic [N*K-1:0] result,
  output logic           carry_out,
  output logic           overflow,
  output logic           done_valid,
  input  logic           done_ready,
  output logic           busy
);

  localparam int unsigned W    = N * K;
  localparam int unsigned CntW = cnt_width(K);
  localparam logic [CntW-1:0] CntLast = CntW'(K - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_out_q, carry_out_d;
  logic            overflow_q, overflow_d;

  logic [N-1:0]    slice_a, slice_b, slice_sum;
  logic            slice_cout;
  int unsigned     slice_lsb;

  assign slice_lsb = int'(cnt_q) * N;
  assign slice_a   = a_q[slice_lsb +: N];
  assign slice_b   = b_q[slice_lsb +: N];

  n_bit_adder_slice #(
    .N(N)
  ) u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    start_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        start_ready = rst_n;
        if (start_valid && rst_n) begin
          a_d     = operand_a;
          b_d     = operand_b;
          carry_d = carry_in;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[slice_lsb +: N] = slice_sum;
        carry_d               = slice_cout;
        if (cnt_q == CntLast) begin
          // sum_d already includes the final slice, so publish it directly.
          result_d    = sum_d;
          carry_out_d = slice_cout;
          overflow_d  = (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (done_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign result     = result_q;
  assign carry_out  = carry_out_q;
  assign overflow   = overflow_q;
  assign done_valid = (state_q == StDone);
  assign busy       = (state_q != StIdle);

endmodule
